// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 link: register addresses, the power-up word list
// and the scheduler state encoding.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam int unsigned INIT_COUNT = 5;

  typedef enum logic [1:0] {StWait, StInit, StIdle, StIssue} sched_state_e;

  function automatic logic [15:0] intensity_word(input logic [3:0] level);
    return {4'h0, ADDR_INTENSITY, 4'h0, level};
  endfunction

  // Init order: shut down, raw segments, scan all 8 digits, brightness, wake up.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] level);
    case (idx)
      3'd0:    return {4'h0, ADDR_SHUTDOWN, 8'h00};
      3'd1:    return {4'h0, ADDR_DECODE, 8'h00};
      3'd2:    return {4'h0, ADDR_SCANLIMIT, 8'h07};
      3'd3:    return intensity_word(level);
      default: return {4'h0, ADDR_SHUTDOWN, 8'h01};
    endcase
  endfunction

endpackage

// File: rtl/max7219_shift.sv
// 16-bit MSB-first serializer for the MAX7219: CLK_DIV cycles per io_clk half-period,
// data moves on the falling edge, LOAD rises after the last bit and a done pulse follows.
module max7219_shift #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        active,
  output logic        io_din,
  output logic        io_cs,
  output logic        io_clk
);

  typedef enum logic [1:0] {ShIdle, ShBits, ShTail} shift_state_e;

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  shift_state_e    state;
  logic [CntW-1:0] cnt;
  logic [15:0]     sr;
  logic [3:0]      bit_idx;
  logic            high;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ShIdle;
      cnt     <= '0;
      sr      <= '0;
      bit_idx <= '0;
      high    <= 1'b0;
      done    <= 1'b0;
      io_din  <= 1'b0;
      io_cs   <= 1'b1;
      io_clk  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ShIdle: begin
          if (start) begin
            state   <= ShBits;
            sr      <= word;
            io_din  <= word[15];
            io_cs   <= 1'b0;
            io_clk  <= 1'b0;
            cnt     <= '0;
            bit_idx <= 4'd15;
            high    <= 1'b0;
          end
        end
        ShBits: begin
          if (cnt == CntMax) begin
            cnt    <= '0;
            high   <= !high;
            io_clk <= !high;
            // End of a high phase: io_clk falls, so present the next bit (or release LOAD)
            if (high) begin
              if (bit_idx == 4'd0) begin
                state  <= ShTail;
                io_cs  <= 1'b1;
                io_din <= 1'b0;
              end else begin
                bit_idx <= bit_idx - 4'd1;
                io_din  <= sr[bit_idx - 4'd1];
              end
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        ShTail: begin
          if (cnt == CntMax) begin
            cnt   <= '0;
            done  <= 1'b1;
            state <= ShIdle;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: state <= ShIdle;
      endcase
    end
  end

  assign active = (state != ShIdle);

endmodule

// File: rtl/max7219_scheduler.sv
// MAX7219 link owner: power-up wait, fixed init sequence, then one-word-per-grant
// scheduling of intensity changes and dirty digits (round-robin) onto the shifter.
module max7219_scheduler #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       int_req,
  input  logic [3:0] int_level,
  output logic       init_done,
  output logic       busy,
  output logic       io_din,
  output logic       io_cs,
  output logic       io_clk
);
  import max7219_pkg::*;

  localparam logic [8:0] MaskW = (9'd1 << NUM_DIGITS) - 9'd1;
  localparam logic [7:0] DigitMask = MaskW[7:0];

  sched_state_e state;
  logic [31:0]  wait_cnt;
  logic [2:0]   init_idx;
  logic         init_sent;
  logic         start;
  logic [15:0]  word;
  logic [7:0]   digit_buf [8];
  logic [7:0]   dirty;
  logic [2:0]   ptr;
  logic         int_pending;
  logic [3:0]   intensity;
  logic         sh_done;
  logic         sh_active;
  logic         wr_ok;
  logic         dig_found;
  logic [2:0]   dig_sel;
  logic [3:0]   cand;

  assign wr_ok = (32'(wr_addr) < NUM_DIGITS);

  // First dirty digit at or after ptr, wrapping at NUM_DIGITS
  always_comb begin
    dig_found = 1'b0;
    dig_sel   = '0;
    cand      = '0;
    for (int k = 0; k < 8; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NUM_DIGITS)) cand = cand - 4'(NUM_DIGITS);
      if (!dig_found && (32'(k) < NUM_DIGITS) && dirty[cand[2:0]]) begin
        dig_found = 1'b1;
        dig_sel   = cand[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StWait;
      wait_cnt    <= '0;
      init_idx    <= '0;
      init_sent   <= 1'b0;
      init_done   <= 1'b0;
      start       <= 1'b0;
      word        <= '0;
      dirty       <= DigitMask;
      ptr         <= '0;
      int_pending <= 1'b0;
      intensity   <= 4'd4;
      for (int i = 0; i < 8; i++) digit_buf[i] <= 8'h00;
    end else begin
      start <= 1'b0;
      unique case (state)
        StWait: begin
          if (wait_cnt + 32'd1 >= STARTUP_WAIT) state <= StInit;
          else wait_cnt <= wait_cnt + 32'd1;
        end
        StInit: begin
          if (!init_sent) begin
            start     <= 1'b1;
            word      <= init_word(init_idx, intensity);
            init_sent <= 1'b1;
          end else if (sh_done) begin
            init_sent <= 1'b0;
            if (init_idx == 3'(INIT_COUNT - 1)) begin
              init_done <= 1'b1;
              state     <= StIdle;
            end else begin
              init_idx <= init_idx + 3'd1;
            end
          end
        end
        StIdle: begin
          if (int_pending) begin
            start       <= 1'b1;
            word        <= intensity_word(intensity);
            int_pending <= 1'b0;
            state       <= StIssue;
          end else if (dig_found) begin
            start          <= 1'b1;
            word           <= {4'h0, ADDR_DIGIT0 + {1'b0, dig_sel}, digit_buf[dig_sel]};
            dirty[dig_sel] <= 1'b0;
            ptr            <= (32'(dig_sel) + 32'd1 >= NUM_DIGITS) ? 3'd0 : dig_sel + 3'd1;
            state          <= StIssue;
          end
        end
        StIssue: begin
          if (sh_done) state <= StIdle;
        end
        default: state <= StWait;
      endcase
      // Placed after the grant so a same-cycle write re-marks the digit dirty
      if (wr_en && wr_ok) begin
        digit_buf[wr_addr] <= wr_data;
        dirty[wr_addr]     <= 1'b1;
      end
      if (int_req) begin
        int_pending <= 1'b1;
        intensity   <= int_level;
      end
    end
  end

  assign busy = (state != StIdle) | sh_active | int_pending | (|dirty);

  max7219_shift #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .word  (word),
    .done  (sh_done),
    .active(sh_active),
    .io_din(io_din),
    .io_cs (io_cs),
    .io_clk(io_clk)
  );

endmodule

// File: tb/tb_max7219_scheduler.sv
// Directed bench: decodes the serial pins back into 16-bit words and compares them
// against hand-written expected word lists.
module tb_max7219_scheduler;

  localparam int unsigned Div = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr_en, int_req;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] int_level;
  logic       init_done, busy, io_din, io_cs, io_clk;

  logic       wr_en4, int_req4;
  logic [2:0] wr_addr4;
  logic [7:0] wr_data4;
  logic [3:0] int_level4;
  logic       init_done4, busy4, io_din4, io_cs4, io_clk4;

  max7219_scheduler #(
    .STARTUP_WAIT(32'd20),
    .CLK_DIV     (Div),
    .NUM_DIGITS  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .int_req  (int_req),
    .int_level(int_level),
    .init_done(init_done),
    .busy     (busy),
    .io_din   (io_din),
    .io_cs    (io_cs),
    .io_clk   (io_clk)
  );

  max7219_scheduler #(
    .STARTUP_WAIT(32'd20),
    .CLK_DIV     (Div),
    .NUM_DIGITS  (4)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en4),
    .wr_addr  (wr_addr4),
    .wr_data  (wr_data4),
    .int_req  (int_req4),
    .int_level(int_level4),
    .init_done(init_done4),
    .busy     (busy4),
    .io_din   (io_din4),
    .io_cs    (io_cs4),
    .io_clk   (io_clk4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor for the 8-digit instance, sampled on the falling clk edge
  logic [15:0] words[$];
  logic [15:0] sh = '0;
  int   bitcnt = 0, len_bad = 0, din_viol = 0, min_gap = 1000;
  int   cyc = 0, fall_cyc = 0, rise_cyc = 0;
  logic rise_seen = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0, prev_din = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !io_cs) begin
      bitcnt   = 0;
      fall_cyc = cyc;
      if (rise_seen && (cyc - rise_cyc) < min_gap) min_gap = cyc - rise_cyc;
    end else if (!io_cs && (io_din !== prev_din) && !(prev_sclk && !io_clk)) begin
      din_viol++;
    end
    if (!io_cs && !prev_sclk && io_clk) begin
      sh = {sh[14:0], io_din};
      bitcnt++;
    end
    if (!prev_cs && io_cs) begin
      if (bitcnt == 16) begin
        words.push_back(sh);
        if ((cyc - fall_cyc) != 32 * Div) len_bad++;
      end
      rise_cyc  = cyc;
      rise_seen = 1'b1;
    end
    prev_cs   = io_cs;
    prev_sclk = io_clk;
    prev_din  = io_din;
  end

  // Lighter monitor for the 4-digit instance
  int          falls4 = 0, rises4 = 0;
  logic [15:0] sh4 = '0, last4 = '0;
  logic        p_cs4 = 1'b1, p_clk4 = 1'b0, busy4_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      falls4 = 0;
      rises4 = 0;
    end else begin
      if (p_cs4 && !io_cs4) falls4++;
      if (!io_cs4 && !p_clk4 && io_clk4) begin
        sh4 = {sh4[14:0], io_din4};
        rises4++;
      end
      if (!p_cs4 && io_cs4) last4 = sh4;
    end
    p_cs4  = io_cs4;
    p_clk4 = io_clk4;
  end

  function automatic logic [15:0] word_at(input int i);
    if (i < words.size()) return words[i];
    return 16'hxxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    tick(3);
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, busy, 0);
  endtask

  task automatic wait_cs_low(input string tag, input int budget);
    int n = 0;
    while (io_cs && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, io_cs, 0);
  endtask

  task automatic write_digit(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic check_boot(input string pfx);
    logic [15:0] exp_boot [13];
    exp_boot = '{16'h0C00, 16'h0900, 16'h0B07, 16'h0A04, 16'h0C01,
                 16'h0100, 16'h0200, 16'h0300, 16'h0400,
                 16'h0500, 16'h0600, 16'h0700, 16'h0800};
    check_eq({pfx, "_count"}, words.size(), 13);
    for (int i = 0; i < 13; i++)
      check_eq($sformatf("%s_w%0d", pfx, i), word_at(i), exp_boot[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; int_req = 1'b0; int_level = '0;
    wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; int_req4 = 1'b0; int_level4 = '0;
    tick(3);
    check_eq("rst_cs", io_cs, 1);
    check_eq("rst_sclk", io_clk, 0);
    check_eq("rst_din", io_din, 0);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_busy", busy, 1);

    rst = 1'b0;
    n = 0;
    while (io_cs && n < 100) begin
      tick(1);
      n++;
    end
    check_eq("startup_idle_ge20", n >= 20, 1);
    wait_idle("boot_idle", 3000);
    check_eq("init_done", init_done, 1);
    check_boot("boot");

    // Intensity request and digit 0 write together, digit 5 one cycle later
    words.delete();
    int_req = 1'b1; int_level = 4'd9;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h3C;
    tick(1);
    int_req = 1'b0;
    wr_addr = 3'd5; wr_data = 8'h81;
    tick(1);
    wr_en = 1'b0;
    wait_idle("prio_idle", 1000);
    check_eq("prio_count", words.size(), 3);
    check_eq("prio_w0", word_at(0), 16'h0A09);
    check_eq("prio_w1", word_at(1), 16'h013C);
    check_eq("prio_w2", word_at(2), 16'h0681);

    words.delete();
    write_digit(3'd3, 8'hA5);
    wait_idle("single_idle", 500);
    check_eq("single_count", words.size(), 1);
    check_eq("single_w0", word_at(0), 16'h04A5);

    // Rewrite while the digit is on the wire
    words.delete();
    write_digit(3'd2, 8'h11);
    wait_cs_low("resend_start", 50);
    tick(20);
    write_digit(3'd2, 8'h22);
    wait_idle("resend_idle", 1000);
    check_eq("resend_count", words.size(), 2);
    check_eq("resend_w0", word_at(0), 16'h0311);
    check_eq("resend_w1", word_at(1), 16'h0322);

    // Two intensity requests while pending collapse into one word
    words.delete();
    write_digit(3'd6, 8'h42);
    wait_cs_low("int_merge_start", 50);
    int_req = 1'b1; int_level = 4'd2;
    tick(1);
    int_level = 4'd7;
    tick(1);
    int_req = 1'b0;
    wait_idle("int_merge_idle", 1000);
    check_eq("int_merge_count", words.size(), 2);
    check_eq("int_merge_w0", word_at(0), 16'h0742);
    check_eq("int_merge_w1", word_at(1), 16'h0A07);

    check_eq("cs_low_len_bad", len_bad, 0);
    check_eq("cs_gap_ge2", min_gap >= 2, 1);

    // Reset during bit 7 of a word
    words.delete();
    write_digit(3'd1, 8'h55);
    n = 0;
    while (bitcnt != 8 && n < 500) begin
      tick(1);
      n++;
    end
    check_eq("mid_word_reached", bitcnt, 8);
    rst = 1'b1;
    tick(1);
    check_eq("midrst_cs", io_cs, 1);
    check_eq("midrst_sclk", io_clk, 0);
    check_eq("midrst_init_done", init_done, 0);
    check_eq("midrst_busy", busy, 1);
    tick(2);
    check_eq("midrst_partial_dropped", words.size(), 0);
    rst = 1'b0;
    wait_idle("reboot_idle", 3000);
    check_eq("reboot_init_done", init_done, 1);
    check_boot("reboot");

    // Four-digit instance: 5 init + 4 digit words, then an out-of-range write
    check_eq("d4_init_done", init_done4, 1);
    check_eq("d4_busy", busy4, 0);
    check_eq("d4_words", falls4, 9);
    check_eq("d4_bits", rises4, 9 * 16);
    check_eq("d4_last_word", last4, 16'h0400);
    wr_en4 = 1'b1; wr_addr4 = 3'd7; wr_data4 = 8'hFF;
    tick(1);
    wr_en4 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy4) busy4_seen = 1'b1;
      tick(1);
    end
    check_eq("d4_oob_busy_seen", busy4_seen, 0);
    check_eq("d4_oob_no_word", falls4, 9);

    check_eq("din_moves_on_fall_only", din_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max7219_scheduler.md
Name: max7219_scheduler

Overview:
- Owns the MAX7219 serial link on the Tang Nano 9K display board.
- Waits out power-up, then issues the fixed init sequence.
- Afterwards it schedules 16-bit register writes from two requesters onto the single serial shifter: a digit buffer with per-digit dirty bits, and an intensity-change request.
- Sits between user logic (counters/clock display) and the io_din/io_cs/io_clk pins.

Parameters:
- STARTUP_WAIT, 32'd10000000, clk cycles to wait after reset before the first word.
- CLK_DIV, 4, clk cycles per io_clk half-period (≥1).
- NUM_DIGITS, 8, digit registers served (1..8).

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  digit-buffer write strobe
- wr_addr  in  3  digit index 0..NUM_DIGITS-1; writes with index ≥ NUM_DIGITS are ignored
- wr_data  in  8  segment pattern (no-decode mode)
- int_req  in  1  one-cycle intensity-change request
- int_level  in  4  intensity value, sampled when int_req=1
- init_done  out  1  high once all init words are sent
- busy  out  1  high while a word is in flight or a request is pending
- io_din  out  1  serial data, MSB first
- io_cs  out  1  chip select (LOAD), active low
- io_clk  out  1  serial clock, idle low

Behaviour:
- Reset values: io_cs=1, io_clk=0, io_din=0, init_done=0, busy=1.
- Reset also sets: digit buffer all 0x00; dirty bits all 1; int_pending=0; intensity register=4; state=WAIT.
- Reset mid-word: io_cs=1 and io_clk=0 on the next edge; the partial word is discarded and the state returns to WAIT.
- FSM states: WAIT → INIT → IDLE ↔ ISSUE.
  - WAIT: count to STARTUP_WAIT, then go to INIT.
  - INIT: send 5 words in order: 0x0C00 (shutdown), 0x0900 (no decode), 0x0B07 (scan 8 digits), {0x0A, 4'h0, intensity}, 0x0C01 (wake).
  - init_done is set on the cycle the 5th word's done pulse is seen; state moves to IDLE.
- Arbitration in IDLE, one word per grant. Priority: int_pending first, then the lowest dirty digit index at or after a rotating pointer (round-robin). The pointer advances past each served digit.
- Word formats:
  - Digit i: {4'h0, i+1 (4 bits), buffer[i]}.
  - Intensity: {8'h0A, 4'h0, intensity}.
- At issue: the word is latched into the shifter, the selected dirty bit (or int_pending) is cleared, and the state goes to ISSUE until done.
- Simultaneous events:
  - A write in the same cycle as a clear on the same digit leaves the dirty bit set (set wins); buffer takes new data.
  - A write during transmission of that digit sets dirty, so the digit is resent with the new value.
  - int_req while int_pending=1 overwrites the level; only one intensity word is sent.
  - int_req during WAIT/INIT updates the intensity register and sets int_pending.
  - Digit writes during WAIT/INIT are buffered and sent after init.
- Shifter timing, with D=CLK_DIV:
  - Start cycle: io_cs falls and io_din = bit 15.
  - Per bit: D cycles with io_clk=0, then D cycles with io_clk=1 (MAX7219 samples on the rising edge). io_din changes only on the falling edge of io_clk.
  - After bit 0's high phase: io_clk=0, io_cs=1 for D cycles, then a one-cycle done pulse.
  - Word latency: start→done = 33·D cycles; ISSUE→IDLE→next start adds 2 cycles.
- busy = (state≠IDLE) | shifter active | int_pending | any dirty bit.

Decomposition:
- Package max7219_pkg holds:
  - Register address constants: NOOP 0x0, DIGIT0 0x1, DECODE 0x9, INTENSITY 0xA, SCANLIMIT 0xB, SHUTDOWN 0xC, TEST 0xF.
  - Init word list and count (5).
  - FSM state encoding.
- Sub-module max7219_shift handles the 16-bit serializer with CLK_DIV.
  - Inputs: clk, rst, start, word[15:0].
  - Outputs: done, active, io_din, io_cs, io_clk.
  - Holds no scheduling logic.

Test Plan:
- STARTUP_WAIT=20, CLK_DIV=2, reset then release → pins idle for 20 cycles; the SPI monitor decodes 0x0C00, 0x0900, 0x0B07, 0x0A04, 0x0C01; init_done rises; then 0x0100…0x0800 each once; busy falls.
- Idle, write addr 3 = 0xA5 → exactly one word 0x04A5; each word is 66 cycles start→done, with io_cs high ≥2 cycles between words.
- Same cycle: int_req level 9, plus writes to digits 0 and 5 → words in order 0x0A09, 0x0100+d0, 0x0600+d5.
- Write digit 2 = 0x11, then write 0x22 mid-transmission → 0x0311 then 0x0322; no further words.
- Assert rst at bit 7 of a word → io_cs=1 and io_clk=0 next cycle; init_done=0; the full init sequence repeats after 20 cycles.
- Write digit with wr_addr=7 while NUM_DIGITS=4 → no word sent; busy stays low.
